// File: rtl/debouncer_multi_ch.sv
// Multi-channel debouncer with delayed press and release.
// Each channel has a two-flop synchroniser, a stability counter and a
// four-state filter FSM. The FSM drives a registered level output and
// one-cycle rise/fall pulses.
module debouncer_multi_ch #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned RESET_VAL     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] noisy,
    output logic [NUM_CH-1:0] debounced,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              any_change
);

    localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic RstLvl = (RESET_VAL != 0);

    typedef enum logic [1:0] {
        StLo    = 2'd0,
        StChkHi = 2'd1,
        StHi    = 2'd2,
        StChkLo = 2'd3
    } state_e;

    localparam state_e RstState = RstLvl ? StHi : StLo;

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CntW-1:0]   cnt_q   [NUM_CH];
    logic [CntW-1:0]   cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] deb_d;
    logic [NUM_CH-1:0] deb_q;
    logic [NUM_CH-1:0] rise_q;
    logic [NUM_CH-1:0] fall_q;
    logic              any_q;

    // Two-flop synchroniser bringing the raw inputs into the clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= {NUM_CH{RstLvl}};
            sync2_q <= {NUM_CH{RstLvl}};
        end else begin
            sync1_q <= noisy;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel filter: next state, counter update and level decode
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StLo: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StChkHi;
                        cnt_d[i]   = '0;
                    end
                end
                StChkHi: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StLo;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = StHi;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StHi: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StChkLo;
                        cnt_d[i]   = '0;
                    end
                end
                StChkLo: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StHi;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = StLo;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    state_d[i] = RstState;
                    cnt_d[i]   = '0;
                end
            endcase
            // Decode from the next state so the level changes on the same edge the FSM settles
            deb_d[i] = (state_d[i] == StHi) || (state_d[i] == StChkLo);
        end
    end

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                state_q[i] <= RstState;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Registered level and edge pulses; a pulse marks the first cycle at the new level
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q  <= {NUM_CH{RstLvl}};
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            deb_q  <= deb_d;
            rise_q <= deb_d & ~deb_q;
            fall_q <= ~deb_d & deb_q;
            any_q  <= |(deb_d ^ deb_q);
        end
    end

    assign debounced  = deb_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign any_change = any_q;

endmodule

// File: tb/tb_debouncer_multi_ch.sv
// Self-checking bench for debouncer_multi_ch.
// Two instances with STABLE_CYCLES=4: one resets low, one resets high.
// Expected outputs are queued when stimulus is driven, keyed by edge number.
module tb_debouncer_multi_ch;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] noisy_a, noisy_b;
    logic [3:0] deb_a, rise_a, fall_a;
    logic [3:0] deb_b, rise_b, fall_b;
    logic       any_a, any_b;

    typedef struct {
        int          at;
        bit          b;
        logic [12:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    debouncer_multi_ch #(
        .NUM_CH(4), .STABLE_CYCLES(4), .RESET_VAL(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .noisy(noisy_a), .debounced(deb_a),
        .rise(rise_a), .fall(fall_a), .any_change(any_a)
    );

    debouncer_multi_ch #(
        .NUM_CH(4), .STABLE_CYCLES(4), .RESET_VAL(1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .noisy(noisy_b), .debounced(deb_b),
        .rise(rise_b), .fall(fall_b), .any_change(any_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    // Queue one expected {debounced, rise, fall, any_change} for a given edge
    task automatic push_ev(input int at, input bit b, input logic [3:0] deb,
                           input logic [3:0] rs, input logic [3:0] fl, input string tag);
        exp_t e;
        e.at  = at;
        e.b   = b;
        e.v   = {deb, rs, fl, |(rs | fl)};
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Queue a steady level with no pulses over an inclusive edge range
    task automatic push_hold(input int from, input int to, input bit b, input logic [3:0] deb,
                             input string tag);
        for (int k = from; k <= to; k++) push_ev(k, b, deb, 4'h0, 4'h0, tag);
    endtask

    // Advance one edge, sample 1 time unit later, compare everything due at this edge
    task automatic tick();
        logic [12:0] got;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                got = sb[i].b ? {deb_b, rise_b, fall_b, any_b} : {deb_a, rise_a, fall_a, any_a};
                check_eq(sb[i].tag, {19'd0, got}, {19'd0, sb[i].v});
                sb.delete(i);
            end
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        reset   = 1'b1;
        noisy_a = 4'hF;
        noisy_b = 4'hF;
        push_hold(1, 3, 0, 4'h0, "rst_a");
        push_hold(1, 20, 1, 4'hF, "idle_b");
        run_to(3);
        reset = 1'b0;
        push_hold(4, 14, 0, 4'h0, "post_rst_a");
        run_to(4);
        noisy_a = 4'h0;

        // Clean press on channel 0: E=15, level follows at E+6
        run_to(14);
        noisy_a = 4'b0001;
        push_hold(15, 20, 0, 4'h0, "press_wait");
        push_ev(21, 0, 4'b0001, 4'b0001, 4'h0, "press_rise");
        push_hold(22, 24, 0, 4'b0001, "press_hold");

        // Release on the high-reset instance: E=21, fall at 27
        run_to(20);
        noisy_b = 4'b1110;
        push_hold(21, 26, 1, 4'hF, "rel_b_wait");
        push_ev(27, 1, 4'b1110, 4'h0, 4'b0001, "fall_b");
        push_hold(28, 101, 1, 4'b1110, "b_low");

        // Channel 1 glitch (4 samples high) is rejected
        run_to(24);
        noisy_a = 4'b0011;
        push_hold(25, 38, 0, 4'b0001, "glitch_a");
        run_to(28);
        noisy_a = 4'b0001;

        // Second press on channel 1: E=33, rise at 39
        run_to(32);
        noisy_a = 4'b0011;
        push_ev(39, 0, 4'b0011, 4'b0010, 4'h0, "press2_rise");
        push_hold(40, 42, 0, 4'b0011, "press2_hold");

        // Bring channel 2 high: E=43, rise at 49
        run_to(42);
        noisy_a = 4'b0111;
        push_hold(43, 48, 0, 4'b0011, "ch2_wait");
        push_ev(49, 0, 4'b0111, 4'b0100, 4'h0, "ch2_rise");
        push_hold(50, 52, 0, 4'b0111, "ch2_hold");

        // Release bounce on channel 2: low 3, high 1, then low from E=57 -> fall at 63
        run_to(52);
        noisy_a = 4'b0011;
        push_hold(53, 62, 0, 4'b0111, "bounce");
        push_ev(63, 0, 4'b0011, 4'h0, 4'b0100, "bounce_fall");
        push_hold(64, 66, 0, 4'b0011, "bounce_after");
        run_to(55);
        noisy_a = 4'b0111;
        run_to(56);
        noisy_a = 4'b0011;

        // Release channels 0 and 1 together
        run_to(66);
        noisy_a = 4'b0000;
        push_hold(67, 72, 0, 4'b0011, "rel_wait");
        push_ev(73, 0, 4'b0000, 4'h0, 4'b0011, "rel_fall");
        push_hold(74, 76, 0, 4'b0000, "rel_after");

        // Simultaneous press 0000 -> 1011
        run_to(76);
        noisy_a = 4'b1011;
        push_hold(77, 82, 0, 4'h0, "simul_wait");
        push_ev(83, 0, 4'b1011, 4'b1011, 4'h0, "simul_rise");
        push_hold(84, 86, 0, 4'b1011, "simul_hold");

        run_to(86);
        noisy_a = 4'b0000;
        push_hold(87, 92, 0, 4'b1011, "simul_rel_wait");
        push_ev(93, 0, 4'h0, 4'h0, 4'b1011, "simul_fall");
        push_hold(94, 101, 0, 4'h0, "pre_rst");

        // Channel 3 press; reset lands while it is in CHK_HI with cnt=2
        run_to(96);
        noisy_a = 4'b1000;
        run_to(101);
        reset = 1'b1;
        push_hold(102, 109, 0, 4'h0, "mid_rst_a");
        push_hold(102, 109, 1, 4'hF, "mid_rst_b");
        run_to(103);
        reset = 1'b0;
        // First non-reset edge 104 acts as E, so both channels requalify at 110
        push_ev(110, 0, 4'b1000, 4'b1000, 4'h0, "requal_rise");
        push_ev(110, 1, 4'b1110, 4'h0, 4'b0001, "requal_fall_b");
        push_hold(111, 114, 0, 4'b1000, "requal_hold_a");
        push_hold(111, 114, 1, 4'b1110, "requal_hold_b");
        run_to(116);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
